// File: rtl/cdc_loop_fifo.sv
// Per-channel byte FIFOs between the usb_cdc OUT and IN streams, with an optional
// fixed channel rotation. Flags are registered from the next level, so s_ready_o has no combinational path.
module cdc_loop_fifo #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16,
  parameter int ROTATE   = 0,
  parameter int LW       = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [8*CHANNELS-1:0]  s_data_i,
  input  logic [CHANNELS-1:0]    s_valid_i,
  output logic [CHANNELS-1:0]    s_ready_o,
  output logic [8*CHANNELS-1:0]  m_data_o,
  output logic [CHANNELS-1:0]    m_valid_o,
  input  logic [CHANNELS-1:0]    m_ready_i,
  input  logic [CHANNELS-1:0]    flush_i,
  output logic [LW*CHANNELS-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [CHANNELS-1:0] fifo_ready;
  logic [CHANNELS-1:0] fifo_valid;
  logic [7:0]          fifo_head [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_fifo
    localparam int OUT_CH = (i + ROTATE) % CHANNELS;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_nxt;
    logic          ready_q;
    logic          valid_q;
    logic          wr;
    logic          rd;

    assign wr = s_valid_i[i] & ready_q;
    assign rd = valid_q & m_ready_i[OUT_CH];

    always_comb begin
      level_nxt = level;
      if (flush_i[i])
        level_nxt = '0;
      else if (wr && !rd)
        level_nxt = level + LW'(1);
      else if (rd && !wr)
        level_nxt = level - LW'(1);
    end

    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        ready_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        if (flush_i[i]) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (wr) wr_ptr <= wr_ptr + PW'(1);
          if (rd) rd_ptr <= rd_ptr + PW'(1);
        end
        level   <= level_nxt;
        ready_q <= (level_nxt < LW'(DEPTH));
        valid_q <= (level_nxt != '0);
      end
    end

    // Storage has no reset so it can map onto RAM; the head is read asynchronously.
    always_ff @(posedge clk_i) begin
      if (rstn_i && wr && !flush_i[i])
        mem[wr_ptr] <= s_data_i[8*i +: 8];
    end

    assign fifo_ready[i]          = ready_q;
    assign fifo_valid[i]          = valid_q;
    assign fifo_head[i]           = mem[rd_ptr];
    assign level_o[LW*i +: LW]    = level;
  end

  assign s_ready_o = fifo_ready;

  for (genvar o = 0; o < CHANNELS; o++) begin : g_out
    localparam int SRC = (o + CHANNELS - ROTATE) % CHANNELS;

    assign m_valid_o[o]      = fifo_valid[SRC];
    assign m_data_o[8*o +: 8] = fifo_valid[SRC] ? fifo_head[SRC] : 8'h00;
  end

endmodule

// File: tb/tb_cdc_loop_fifo.sv
// Bench for cdc_loop_fifo: queue scoreboard checked every cycle, a vector table for
// fill/wrap, and hand sequences for reset, flush, concurrent read/write and rotation.
module tb_cdc_loop_fifo;
  localparam int CH = 2;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]     sd = '0, md, sd_r = '0, md_r;
  logic [1:0]      sv = '0, srdy, mv, mr = '0, fl = '0;
  logic [1:0]      sv_r = '0, srdy_r, mv_r, mr_r = '0, fl_r = '0;
  logic [2*LW-1:0] lvl, lvl_r;

  cdc_loop_fifo #(.CHANNELS(CH), .DEPTH(D), .ROTATE(0)) u0 (
    .clk_i(clk), .rstn_i(rstn), .s_data_i(sd), .s_valid_i(sv), .s_ready_o(srdy),
    .m_data_o(md), .m_valid_o(mv), .m_ready_i(mr), .flush_i(fl), .level_o(lvl));

  cdc_loop_fifo #(.CHANNELS(CH), .DEPTH(D), .ROTATE(1)) u1 (
    .clk_i(clk), .rstn_i(rstn), .s_data_i(sd_r), .s_valid_i(sv_r), .s_ready_o(srdy_r),
    .m_data_o(md_r), .m_valid_o(mv_r), .m_ready_i(mr_r), .flush_i(fl_r), .level_o(lvl_r));

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int  mlvl [2];
  bit  in_rst = 1'b1;

  typedef struct {
    logic [1:0]    v;
    logic [7:0]    d;
    logic [1:0]    r;
    logic          er;
    logic          ev;
    logic [LW-1:0] el;
    logic [7:0]    ed;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < 2; c++) begin
      logic [7:0] front;
      int qs;
      qs = (c == 0) ? q0.size() : q1.size();
      front = 8'h00;
      if (qs > 0) front = (c == 0) ? q0[0] : q1[0];
      chk($sformatf("s_ready[%0d]", c), 32'(srdy[c]), 32'(!in_rst && mlvl[c] < D));
      chk($sformatf("m_valid[%0d]", c), 32'(mv[c]), 32'(!in_rst && mlvl[c] > 0));
      chk($sformatf("level[%0d]", c), 32'(lvl[LW*c +: LW]), 32'(mlvl[c]));
      if (in_rst)
        chk($sformatf("rst_data[%0d]", c), 32'(md[8*c +: 8]), 32'h0);
      else if (mlvl[c] > 0)
        chk($sformatf("head[%0d]", c), 32'(md[8*c +: 8]), 32'(front));
    end
  endtask

  // One clock of u0: model is advanced from pre-edge state, then outputs compared after the edge.
  task automatic step(input logic r, input logic [1:0] v, input logic [15:0] d,
                      input logic [1:0] rdy, input logic [1:0] f);
    rstn = r; sv = v; sd = d; mr = rdy; fl = f;
    for (int c = 0; c < 2; c++) begin
      bit wr, rd;
      wr = v[c] && !in_rst && mlvl[c] < D;
      rd = rdy[c] && !in_rst && mlvl[c] > 0;
      if (!r || f[c]) begin
        if (c == 0) q0.delete(); else q1.delete();
        mlvl[c] = 0;
      end else begin
        if (rd) begin
          if (c == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          mlvl[c]--;
        end
        if (wr) begin
          if (c == 0) q0.push_back(d[7:0]); else q1.push_back(d[15:8]);
          mlvl[c]++;
        end
      end
    end
    in_rst = !r;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    mlvl[0] = 0;
    mlvl[1] = 0;
    tbl[0]  = '{2'b01, 8'h01, 2'b00, 1'b1, 1'b1, 3'd1, 8'h01};
    tbl[1]  = '{2'b01, 8'h02, 2'b00, 1'b1, 1'b1, 3'd2, 8'h01};
    tbl[2]  = '{2'b01, 8'h03, 2'b00, 1'b1, 1'b1, 3'd3, 8'h01};
    tbl[3]  = '{2'b01, 8'h04, 2'b00, 1'b0, 1'b1, 3'd4, 8'h01};
    tbl[4]  = '{2'b01, 8'h55, 2'b00, 1'b0, 1'b1, 3'd4, 8'h01};
    tbl[5]  = '{2'b00, 8'h00, 2'b01, 1'b1, 1'b1, 3'd3, 8'h02};
    tbl[6]  = '{2'b00, 8'h00, 2'b01, 1'b1, 1'b1, 3'd2, 8'h03};
    tbl[7]  = '{2'b01, 8'h05, 2'b00, 1'b1, 1'b1, 3'd3, 8'h03};
    tbl[8]  = '{2'b01, 8'h06, 2'b00, 1'b0, 1'b1, 3'd4, 8'h03};
    tbl[9]  = '{2'b00, 8'h00, 2'b01, 1'b1, 1'b1, 3'd3, 8'h04};
    tbl[10] = '{2'b00, 8'h00, 2'b01, 1'b1, 1'b1, 3'd2, 8'h05};
    tbl[11] = '{2'b00, 8'h00, 2'b01, 1'b1, 1'b1, 3'd1, 8'h06};
    tbl[12] = '{2'b00, 8'h00, 2'b01, 1'b1, 1'b0, 3'd0, 8'h00};

    // Reset with valid asserted
    for (int k = 0; k < 3; k++) step(1'b0, 2'b11, 16'h1234, 2'b00, 2'b00);
    chk("rst_ready", 32'(srdy), 32'h0);
    chk("rst_valid", 32'(mv), 32'h0);
    chk("rst_level", 32'(lvl), 32'h0);
    chk("rst_u1_ready", 32'(srdy_r), 32'h0);
    step(1'b1, 2'b00, 16'h0, 2'b00, 2'b00);
    chk("release_ready", 32'(srdy), 32'h3);

    // Single byte
    step(1'b1, 2'b01, 16'h00A5, 2'b00, 2'b00);
    chk("single_valid", 32'(mv[0]), 32'h1);
    chk("single_data", 32'(md[7:0]), 32'hA5);
    step(1'b1, 2'b00, 16'h0, 2'b01, 2'b00);
    chk("single_drain_valid", 32'(mv[0]), 32'h0);
    chk("single_drain_level", 32'(lvl[LW-1:0]), 32'h0);

    // Fill, overflow attempt, wrap
    for (int k = 0; k < 13; k++) begin
      step(1'b1, tbl[k].v, {8'h00, tbl[k].d}, tbl[k].r, 2'b00);
      chk($sformatf("tbl%0d_ready", k), 32'(srdy[0]), 32'(tbl[k].er));
      chk($sformatf("tbl%0d_valid", k), 32'(mv[0]), 32'(tbl[k].ev));
      chk($sformatf("tbl%0d_level", k), 32'(lvl[LW-1:0]), 32'(tbl[k].el));
      if (tbl[k].ev) chk($sformatf("tbl%0d_data", k), 32'(md[7:0]), 32'(tbl[k].ed));
    end

    // Concurrent read and write at level 2
    step(1'b1, 2'b01, 16'h0030, 2'b00, 2'b00);
    step(1'b1, 2'b01, 16'h0031, 2'b00, 2'b00);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 2'b01, 16'(8'h32 + k), 2'b01, 2'b00);
      chk("rw_level", 32'(lvl[LW-1:0]), 32'h2);
      chk("rw_ready", 32'(srdy[0]), 32'h1);
    end
    step(1'b1, 2'b00, 16'h0, 2'b01, 2'b00);
    step(1'b1, 2'b00, 16'h0, 2'b01, 2'b00);

    // Flush ch1 while ch0 holds data
    step(1'b1, 2'b11, 16'hB0C0, 2'b00, 2'b00);
    step(1'b1, 2'b11, 16'hB1C1, 2'b00, 2'b00);
    step(1'b1, 2'b10, 16'hB200, 2'b00, 2'b00);
    step(1'b1, 2'b10, 16'hEE00, 2'b00, 2'b10);
    chk("flush_lvl1", 32'(lvl[2*LW-1:LW]), 32'h0);
    chk("flush_lvl0", 32'(lvl[LW-1:0]), 32'h2);
    chk("flush_valid", 32'(mv), 32'h1);
    chk("flush_ready", 32'(srdy), 32'h3);
    chk("flush_ch0_head", 32'(md[7:0]), 32'hC0);
    step(1'b1, 2'b00, 16'h0, 2'b01, 2'b00);
    step(1'b1, 2'b00, 16'h0, 2'b01, 2'b00);

    // Reset mid-transfer
    step(1'b1, 2'b11, 16'h7788, 2'b00, 2'b00);
    step(1'b0, 2'b11, 16'h99AA, 2'b00, 2'b00);
    step(1'b1, 2'b00, 16'h0, 2'b00, 2'b00);
    chk("midrst_level", 32'(lvl), 32'h0);
    chk("midrst_valid", 32'(mv), 32'h0);

    // Rotation on u1
    sv_r = 2'b11; sd_r = 16'h2211;
    @(posedge clk); #1;
    sv_r = 2'b00;
    chk("rot_hi", 32'(md_r[15:8]), 32'h11);
    chk("rot_lo", 32'(md_r[7:0]), 32'h22);
    chk("rot_valid", 32'(mv_r), 32'h3);
    chk("rot_level", 32'(lvl_r), 32'({3'd1, 3'd1}));
    mr_r = 2'b10;
    @(posedge clk); #1;
    mr_r = 2'b00;
    chk("rot_pop_valid", 32'(mv_r), 32'h1);
    chk("rot_pop_level", 32'(lvl_r), 32'({3'd1, 3'd0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
